demux_dispatch_ctrl: RTL and testbench
======================================

# demux_dispatch_ctrl

Request sequencer that sits directly upstream of the 1:16 demultiplexer and produces its `a` (data/enable) and `s[3:0]` (select) inputs. Channel requests arrive over a valid/ready handshake and are buffered in a small FIFO. Each request is played out as a timed enable pulse on the selected channel. Select changes only while `a` is low, so no transient pulse ever reaches a wrong demux output.

## Interface
- `LEN_W`, 8: width of the pulse-length field.
- `FIFO_DEPTH`, 4: request FIFO entries; must be a power of two, ≥ 2.
- `GUARD_CYCLES`, 1: cycles with `a` low after each pulse; must be ≥ 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: FIFO can accept; high when `count < FIFO_DEPTH`.
- `req_ch` input 4: destination demux channel, 0–15.
- `req_len` input LEN_W: pulse length in cycles.
- `abort` input 1: synchronous flush and stop.
- `a` output 1: demux data/enable; registered.
- `s` output 4: demux select; registered.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse at the end of each pulse's ACTIVE phase.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** a request is pushed on any edge where `req_valid && req_ready`.
- **`req_ready` when full:** `req_ready` depends on registered occupancy only. There is no same-cycle pass-through when the FIFO is full.
- **Pop:** the FSM pops the FIFO head in IDLE, or in the last GUARD cycle.
- **Push and pop together:** a push and a pop on the same edge leave `fifo_count` unchanged. Both operations take effect.

FSM states:
- **IDLE:** `a` = 0 and `s` holds its last value. If the FIFO is non-empty, pop the head, load `s` with `ch`, load the length counter with `len`, and go to SETUP.
- **SETUP:** one cycle with `a` = 0 and the new `s` stable.
  - If `len` ≠ 0: go to ACTIVE and set `a` to 1.
  - If `len` = 0: go directly to GUARD with `a` = 0 and pulse `done`.
- **ACTIVE:** `a` = 1 and the counter decrements each cycle. When the counter reaches 1, go to GUARD on that edge, set `a` to 0 and pulse `done`.
- **GUARD:** `a` = 0 and `s` held for `GUARD_CYCLES` cycles. In the last GUARD cycle:
  - If the FIFO is non-empty, pop and go straight to SETUP.
  - Otherwise go to IDLE.

Abort:
- `abort` has priority over everything else, in any state.
- On the next edge: FIFO cleared, `a` set to 0, state IDLE, counter cleared. `s` keeps its value and `done` is not pulsed.
- A push presented in the same cycle as `abort` is dropped.

Width and range rules:
- `len` is unsigned, 0 to 2^LEN_W−1.
- The counter is LEN_W bits wide and never wraps below 0.
- FIFO pointers wrap modulo `FIFO_DEPTH`.

## Timing
Reset values:
- `a` = 0, `s` = 0, `done` = 0, `busy` = 0, `fifo_count` = 0, `req_ready` = 1, state IDLE.
- Reset asserted mid-pulse drops `a` asynchronously. The FIFO contents are discarded.

Single request accepted at edge E0 with the FSM in IDLE and the FIFO empty:
- E0: `fifo_count` becomes 1.
- E1: pop; `s` = ch, SETUP, `busy` = 1, `fifo_count` = 0.
- E2: `a` = 1.
- `a` is high for exactly `len` cycles, E2 through E(2+len)−1.
- E(2+len): `a` = 0 and `done` = 1 for one cycle.
- Return to IDLE occurs at edge E(2+len+GUARD_CYCLES).

Back-to-back requests:
- The next SETUP begins on the edge that ends GUARD.
- The falling edge of `a` and the next change of `s` are separated by `GUARD_CYCLES` cycles.
- `s` never changes in a cycle where `a` = 1, or in the cycle just before `a` rises.

## Test plan
1. **Reset:** assert `rst_n` low during ACTIVE. `a` drops immediately. After release: `s` = 0, `fifo_count` = 0, `req_ready` = 1.
2. **Single request:** ch = 9, len = 3, GUARD_CYCLES = 1. `s` = 9 from E1, `a` high for exactly 3 cycles starting at E2, `done` high at E5, IDLE and `busy` = 0 after E6. The demux output y[9] is the only output that pulses.
3. **Back-to-back:** push ch = 0/len = 2, ch = 15/len = 1, ch = 7/len = 0 in consecutive cycles. The pulse pattern is ch 0 for 2 cycles, then ch 15 for 1 cycle. Ch 7 produces no `a` pulse but does produce `done`. Three `done` pulses in total, and `s` is stable whenever `a` = 1.
4. **FIFO full:** hold `req_valid` high for 6 requests with len = 8. `req_ready` goes low once the FIFO holds 4 entries. It rises again one cycle after a pop. No request is lost or duplicated, and every request plays out in order.
5. **Abort:** assert `abort` mid-ACTIVE with 2 requests queued, together with a push. On the next edge: `a` = 0, `fifo_count` = 0, IDLE, no `done`. The simultaneous push is dropped.
6. **Maximum length:** len = 255 with LEN_W = 8. `a` is high for exactly 255 cycles and the counter shows no wrap.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// Request sequencer for a 1:16 demux. Requests are queued in a small FIFO
// and each one is played out as a timed enable pulse on `a`. The select `s`
// only changes while `a` is low, so the demux never glitches onto a wrong output.
module demux_dispatch_ctrl #(
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [3:0]                  req_ch,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        abort,
  output logic                        a,
  output logic [3:0]                  s,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [CntW-1:0]   Depth     = CntW'(FIFO_DEPTH);
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StActive, StGuard} state_e;

  // Request FIFO storage and pointers
  logic [3:0]       ch_mem_q  [FIFO_DEPTH];
  logic [LEN_W-1:0] len_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Sequencer state
  state_e           state_q, state_d;
  logic             a_q, a_d;
  logic [3:0]       s_q, s_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GuardW-1:0] guard_q, guard_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [3:0]       head_ch;
  logic [LEN_W-1:0] head_len;

  // Ready is a pure function of registered occupancy: no pass-through when full
  assign req_ready  = (count_q < Depth);
  assign push       = req_valid && req_ready && !abort;
  assign fifo_empty = (count_q == '0);
  assign head_ch    = ch_mem_q[rd_ptr_q];
  assign head_len   = len_mem_q[rd_ptr_q];

  assign a          = a_q;
  assign s          = s_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign fifo_count = count_q;

  // FIFO payload write; contents need no reset since occupancy gates all reads
  always_ff @(posedge clk) begin
    if (push) begin
      ch_mem_q[wr_ptr_q]  <= req_ch;
      len_mem_q[wr_ptr_q] <= req_len;
    end
  end

  // FIFO pointer and occupancy next-state; abort empties the queue
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer next-state: pop, setup, timed pulse, guard gap
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    guard_d = guard_q;
    pop     = 1'b0;
    if (abort) begin
      // s deliberately keeps its value; no done for the cut-short pulse
      state_d = StIdle;
      a_d     = 1'b0;
      cnt_d   = '0;
      guard_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          a_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            s_d     = head_ch;
            cnt_d   = head_len;
            state_d = StSetup;
          end
        end
        StSetup: begin
          if (cnt_q != '0) begin
            a_d     = 1'b1;
            state_d = StActive;
          end else begin
            done_d  = 1'b1;
            guard_d = GuardLast;
            state_d = StGuard;
          end
        end
        StActive: begin
          // Counter is at least 1 here, so the decrement never wraps
          if (cnt_q <= LEN_W'(1)) begin
            a_d     = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            guard_d = GuardLast;
            state_d = StGuard;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
        StGuard: begin
          a_d = 1'b0;
          if (guard_q == '0) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              s_d     = head_ch;
              cnt_d   = head_len;
              state_d = StSetup;
            end else begin
              state_d = StIdle;
            end
          end else begin
            guard_d = guard_q - GuardW'(1);
          end
        end
        default: begin
          a_d     = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // Sequencer registers; reset drops `a` immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= 1'b0;
      s_q     <= 4'd0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: table-driven single requests, hand-written
// multi-cycle sequences, and a scoreboard that pairs every done with its request.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] req_ch = 4'd0;
  logic [7:0] req_len = 8'd0;
  logic       req_ready, a, busy, done;
  logic [3:0] s;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(
    .LEN_W(8),
    .FIFO_DEPTH(4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_ch(req_ch),
    .req_len(req_len),
    .abort(abort),
    .a(a),
    .s(s),
    .busy(busy),
    .done(done),
    .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] len;
  } req_t;

  typedef struct {
    int ch;
    int len;
    int exp_a;     // cycles with a high
    int exp_idle;  // edges from the push edge until busy is low again
  } vec_t;

  req_t       sb_q[$];
  int         n_checks = 0;
  int         n_fails = 0;
  int         run = 0;
  bit         rose = 1'b0;
  logic       a_prev = 1'b0;
  logic [3:0] s_prev = 4'd0;
  int         done_cnt = 0;
  int         a_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard/monitor, evaluated on the falling edge
  task automatic mon();
    if (!rst_n) begin
      sb_q.delete();
      run  = 0;
      rose = 1'b0;
    end else begin
      if (s !== s_prev) check("s_change_only_while_a_low", {31'd0, a | a_prev}, 32'd0);
      if (a) begin
        if (!a_prev) begin
          rose = 1'b1;
          run  = 0;
        end
        run++;
        a_cycles++;
      end
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("done_with_empty_scoreboard", 32'd1, 32'd0);
        end else begin
          req_t e;
          e = sb_q.pop_front();
          check("pulse_channel", {28'd0, s}, {28'd0, e.ch});
          check("pulse_length", rose ? run : 0, {24'd0, e.len});
        end
        run  = 0;
        rose = 1'b0;
      end
      if (abort) begin
        sb_q.delete();
        run  = 0;
        rose = 1'b0;
      end else if (req_valid && req_ready) begin
        sb_q.push_back({req_ch, req_len});
      end
    end
    a_prev = a;
    s_prev = s;
  endtask

  task automatic cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < 2000) begin
      cycle();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_a(input string name);
    int n;
    n = 0;
    while (!a && n < 50) begin
      cycle();
      n++;
    end
    check(name, {31'd0, a}, 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int d0, a0, k, n, ahi;
    bit seen_full, hs;

    vecs[0] = '{ch: 9,  len: 3,   exp_a: 3,   exp_idle: 6};
    vecs[1] = '{ch: 0,  len: 0,   exp_a: 0,   exp_idle: 3};
    vecs[2] = '{ch: 15, len: 1,   exp_a: 1,   exp_idle: 4};
    vecs[3] = '{ch: 5,  len: 255, exp_a: 255, exp_idle: 258};
    vecs[4] = '{ch: 12, len: 8,   exp_a: 8,   exp_idle: 11};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset_a", {31'd0, a}, 32'd0);
    check("reset_s", {28'd0, s}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Single request, edge by edge: ch 9, len 3
    req_valid = 1'b1; req_ch = 4'd9; req_len = 8'd3;
    cycle();  // E0
    req_valid = 1'b0;
    check("e0_fifo_count", {29'd0, fifo_count}, 32'd1);
    check("e0_busy", {31'd0, busy}, 32'd0);
    cycle();  // E1
    check("e1_s", {28'd0, s}, 32'd9);
    check("e1_busy", {31'd0, busy}, 32'd1);
    check("e1_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("e1_a", {31'd0, a}, 32'd0);
    for (int e = 2; e <= 4; e++) begin
      cycle();
      check("e2_e4_a_high", {31'd0, a}, 32'd1);
      check("e2_e4_no_done", {31'd0, done}, 32'd0);
    end
    cycle();  // E5
    check("e5_a", {31'd0, a}, 32'd0);
    check("e5_done", {31'd0, done}, 32'd1);
    check("e5_busy", {31'd0, busy}, 32'd1);
    cycle();  // E6
    check("e6_done", {31'd0, done}, 32'd0);
    check("e6_busy", {31'd0, busy}, 32'd0);

    // Table of isolated requests, including len 0 and maximum length
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_ch = 4'(vecs[i].ch); req_len = 8'(vecs[i].len);
      cycle();
      req_valid = 1'b0;
      check("tbl_push_count", {29'd0, fifo_count}, 32'd1);
      n = 0;
      ahi = 0;
      do begin
        cycle();
        n++;
        if (a) ahi++;
      end while (busy && n < 600);
      check("tbl_a_cycles", ahi, vecs[i].exp_a);
      check("tbl_edges_to_idle", n, vecs[i].exp_idle);
      check("tbl_s_held", {28'd0, s}, vecs[i].ch);
    end

    // Back-to-back: 0/2, 15/1, 7/0
    d0 = done_cnt;
    a0 = a_cycles;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_ch  = (i == 0) ? 4'd0 : (i == 1) ? 4'd15 : 4'd7;
      req_len = (i == 0) ? 8'd2 : (i == 1) ? 8'd1 : 8'd0;
      check("b2b_ready", {31'd0, req_ready}, 32'd1);
      cycle();
    end
    req_valid = 1'b0;
    wait_idle("b2b_idle");
    check("b2b_done_count", done_cnt - d0, 32'd3);
    check("b2b_a_cycles", a_cycles - a0, 32'd3);
    check("b2b_scoreboard_empty", sb_q.size(), 32'd0);

    // FIFO full: 6 requests of len 8 with valid held high
    d0 = done_cnt;
    seen_full = 1'b0;
    k = 0;
    for (int t = 0; t < 300 && k < 6; t++) begin
      req_valid = 1'b1; req_ch = 4'(k + 1); req_len = 8'd8;
      if (!req_ready && !seen_full) begin
        check("full_ready_low_at_depth", {29'd0, fifo_count}, 32'd4);
        seen_full = 1'b1;
      end
      hs = req_ready;
      cycle();
      if (hs) k++;
    end
    req_valid = 1'b0;
    check("full_ready_went_low", {31'd0, seen_full}, 32'd1);
    check("full_all_accepted", k, 32'd6);
    wait_idle("full_idle");
    check("full_done_count", done_cnt - d0, 32'd6);
    check("full_scoreboard_empty", sb_q.size(), 32'd0);

    // Abort mid-ACTIVE with 2 queued and a simultaneous push
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_ch = 4'(2 + i); req_len = 8'd10;
      cycle();
    end
    req_valid = 1'b0;
    wait_a("abort_reached_active");
    check("abort_queued_before", {29'd0, fifo_count}, 32'd2);
    d0 = done_cnt;
    abort = 1'b1; req_valid = 1'b1; req_ch = 4'd8; req_len = 8'd1;
    cycle();
    abort = 1'b0; req_valid = 1'b0;
    check("abort_a", {31'd0, a}, 32'd0);
    check("abort_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 5; i++) cycle();
    check("abort_push_dropped", {31'd0, busy}, 32'd0);
    check("abort_done_count", done_cnt - d0, 32'd0);
    check("abort_s_kept", {28'd0, s}, 32'd2);

    // Reset asserted mid-ACTIVE
    req_valid = 1'b1; req_ch = 4'd6; req_len = 8'd20;
    cycle();
    req_valid = 1'b0;
    wait_a("rst_reached_active");
    rst_n = 1'b0;
    #1;
    check("rst_async_a_drop", {31'd0, a}, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    check("rst_s", {28'd0, s}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Normal operation resumes after reset
    d0 = done_cnt;
    cycle();
    req_valid = 1'b1; req_ch = 4'd3; req_len = 8'd2;
    cycle();
    req_valid = 1'b0;
    wait_idle("post_rst_idle");
    check("post_rst_done_count", done_cnt - d0, 32'd1);
    check("post_rst_s", {28'd0, s}, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
